// File: rtl/xmtarb.sv
// xmtarb: shares one serial transmitter buffer between two byte requesters.
// Each requester owns a one-byte holding register. Bytes are issued
// round-robin. A requester may lock the grant for a bounded burst of bytes
// so that a multi-byte packet is not interleaved with the other side.
module xmtarb #(
    parameter int BURST_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_write,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    input  logic       req1_write,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       xmt_write,
    output logic [7:0] xmt_data,
    input  logic       xmt_ready,
    input  logic       xmt_empty,
    output logic       owner,
    output logic       all_empty
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] C_BURST_MAX = 8'(BURST_MAX);

    logic [1:0] r_state;
    logic [7:0] r_hold0;
    logic [7:0] r_hold1;
    logic       r_full0;
    logic       r_full1;
    logic       r_rr;          // requester favoured when both are full
    logic [7:0] r_burst;
    logic       r_owner;
    logic       r_xmt_write;
    logic [7:0] r_xmt_data;

    logic       w_owner_lock;
    logic       w_owner_full;
    logic       w_lock_active;
    logic       w_avail;
    logic       w_winner;
    logic       w_winner_lock;
    logic       w_issue;
    logic [7:0] w_burst_next;

    assign w_owner_lock  = r_owner ? req1_lock : req0_lock;
    assign w_owner_full  = r_owner ? r_full1 : r_full0;
    assign w_lock_active = w_owner_lock && (r_burst < C_BURST_MAX);
    assign w_winner_lock = w_winner ? req1_lock : req0_lock;
    assign w_issue       = (r_state == ST_IDLE) && xmt_ready && w_avail;

    // Pick the next requester; an active lock blocks the other side entirely.
    always_comb begin
        w_winner = 1'b0;
        w_avail  = 1'b0;
        if (w_lock_active) begin
            w_winner = r_owner;
            w_avail  = w_owner_full;
        end else if (r_full0 && r_full1) begin
            w_winner = r_rr;
            w_avail  = 1'b1;
        end else if (r_full0) begin
            w_winner = 1'b0;
            w_avail  = 1'b1;
        end else if (r_full1) begin
            w_winner = 1'b1;
            w_avail  = 1'b1;
        end else begin
            w_winner = 1'b0;
            w_avail  = 1'b0;
        end
    end

    // Burst length after issuing to the selected winner (saturates at the limit).
    always_comb begin
        w_burst_next = r_burst;
        if (!w_winner_lock) begin
            w_burst_next = 8'd0;
        end else if (w_winner != r_owner) begin
            w_burst_next = 8'd1;
        end else if (r_burst < C_BURST_MAX) begin
            w_burst_next = r_burst + 8'd1;
        end else begin
            w_burst_next = r_burst;
        end
    end

    // Requester 0 holding register: accept only when empty, empty on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full0 <= 1'b0;
            r_hold0 <= 8'd0;
        end else if (w_issue && (w_winner == 1'b0)) begin
            r_full0 <= 1'b0;
        end else if (req0_write && !r_full0) begin
            r_full0 <= 1'b1;
            r_hold0 <= req0_data;
        end
    end

    // Requester 1 holding register: accept only when empty, empty on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full1 <= 1'b0;
            r_hold1 <= 8'd0;
        end else if (w_issue && (w_winner == 1'b1)) begin
            r_full1 <= 1'b0;
        end else if (req1_write && !r_full1) begin
            r_full1 <= 1'b1;
            r_hold1 <= req1_data;
        end
    end

    // Issue FSM: one write pulse, then a settle gap before looking at xmt_ready again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_xmt_write <= 1'b0;
            r_xmt_data  <= 8'd0;
            r_owner     <= 1'b0;
            r_rr        <= 1'b0;
            r_burst     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_xmt_write <= 1'b1;
                        r_xmt_data  <= w_winner ? r_hold1 : r_hold0;
                        r_owner     <= w_winner;
                        r_rr        <= ~w_winner;
                        r_burst     <= w_burst_next;
                        r_state     <= ST_SEND;
                    end else begin
                        r_xmt_write <= 1'b0;
                    end
                end
                ST_SEND: begin
                    r_xmt_write <= 1'b0;
                    r_state     <= ST_GAP;
                end
                ST_GAP: begin
                    r_xmt_write <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_xmt_write <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = ~r_full0;
    assign req1_ready = ~r_full1;
    assign xmt_write  = r_xmt_write;
    assign xmt_data   = r_xmt_data;
    assign owner      = r_owner;
    assign all_empty  = (r_state == ST_IDLE) && !r_full0 && !r_full1 && xmt_empty;

endmodule
